lsu: RTL

- Load/store unit between the core's execute stage, the data-memory bus and the register file write port.
- Takes the store operand read from the register file, the ALU-computed address and a load/store funct3.
- Runs a req/gnt/rvalid bus transaction.
- For loads, produces the aligned, sign/zero-extended write-back word plus its write address and write enable for the register file.

---
 rtl/riscv_lsu_pkg.sv | 31 +++
 rtl/lsu_data_align.sv | 81 ++++++++
 rtl/lsu.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_lsu_pkg
// Description : Shared constants and types for the load/store unit:
//               funct3 access sizes, error codes and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_lsu_pkg;

  // funct3 encodings for loads and stores
  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  // err_o encodings
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_data_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_data_align
// Description : Combinational data formatting for the LSU. The request side
//               checks legality/alignment and builds byte enables and
//               lane-replicated store data; the response side extracts and
//               sign/zero-extends load data from the returned bus word.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_data_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  req_size_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_addr_lo_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        illegal_o,
  output logic        misalign_o,
  input  logic [2:0]  rsp_size_i,
  input  logic [1:0]  rsp_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic        sign_ext;

  // Legality and alignment; an illegal size never also reports misalignment
  always_comb begin
    illegal_o  = 1'b0;
    misalign_o = 1'b0;
    case (req_size_i)
      LDST_B, LDST_BU: misalign_o = 1'b0;
      LDST_H, LDST_HU: misalign_o = req_addr_lo_i[0];
      LDST_W:          misalign_o = (req_addr_lo_i != 2'b00);
      default:         illegal_o  = 1'b1;
    endcase
    // Stores have no unsigned variants
    if (req_we_i && req_size_i[2]) begin
      illegal_o = 1'b1;
    end
    if (illegal_o) begin
      misalign_o = 1'b0;
    end
  end

  // Byte enables and store lane replication (same enables used for loads)
  always_comb begin
    case (req_size_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << req_addr_lo_i;
        wdata_o = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << req_addr_lo_i;
        wdata_o = {2{req_wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = req_wdata_i;
      end
    endcase
  end

  // Load lane extraction and extension; funct3[2] selects zero extension
  always_comb begin
    byte_shift = rdata_i >> {rsp_addr_lo_i, 3'b000};
    half_shift = rdata_i >> {rsp_addr_lo_i[1], 4'b0000};
    sign_ext   = ~rsp_size_i[2];
    case (rsp_size_i[1:0])
      2'b00:   rdata_o = {{24{sign_ext & byte_shift[7]}}, byte_shift[7:0]};
      2'b01:   rdata_o = {{16{sign_ext & half_shift[15]}}, half_shift[15:0]};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Load/store unit. Accepts one access from execute, runs a
//               req/gnt/rvalid bus transaction with a timeout, and returns
//               formatted load data to the register file write port.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  output logic        stall_o,
  output logic [1:0]  err_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_wa_o,
  output logic [31:0] rf_wd_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_t  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [4:0]  rd_q, rd_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_wa_q, rf_wa_d;
  logic [31:0] rf_wd_q, rf_wd_d;
  logic [1:0]  err_q, err_d;

  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic        fmt_illegal;
  logic        fmt_misalign;
  logic [31:0] load_data;
  logic        timeout;

  lsu_data_align u_align (
    .req_size_i    (size_i),
    .req_we_i      (we_i),
    .req_addr_lo_i (addr_i[1:0]),
    .req_wdata_i   (wdata_i),
    .be_o          (fmt_be),
    .wdata_o       (fmt_wdata),
    .illegal_o     (fmt_illegal),
    .misalign_o    (fmt_misalign),
    .rsp_size_i    (size_q),
    .rsp_addr_lo_i (addr_lo_q),
    .rdata_i       (mem_rdata_i),
    .rdata_o       (load_data)
  );

  // Counter already holds (cycles spent - 1); abort on the cycle that reaches the limit
  assign timeout = (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES));

  // Core is held while a legal request is being accepted or the bus access is in flight
  assign stall_o = ((state_q == ST_IDLE) && req_i && !fmt_illegal && !fmt_misalign)
                 || (state_q == ST_REQ) || (state_q == ST_RESP);

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    addr_lo_d   = addr_lo_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rf_we_d     = 1'b0;
    rf_wa_d     = rf_wa_q;
    rf_wd_d     = rf_wd_q;
    err_d       = ERR_NONE;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          if (fmt_illegal) begin
            err_d = ERR_ILLEGAL;
          end else if (fmt_misalign) begin
            err_d = ERR_MISALIGN;
          end else begin
            size_d      = size_i;
            addr_lo_d   = addr_i[1:0];
            rd_d        = rd_i;
            mem_we_d    = we_i;
            mem_be_d    = fmt_be;
            mem_addr_d  = {addr_i[31:2], 2'b00};
            mem_wdata_d = fmt_wdata;
            mem_req_d   = 1'b1;
            cnt_d       = 16'd0;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (timeout) begin
          err_d     = ERR_TIMEOUT;
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q + 16'd1;
        if (timeout) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_IDLE;
        end else if (mem_rvalid_i) begin
          state_d = ST_DONE;
          if (!mem_we_q) begin
            rf_we_d = (rd_q != 5'd0);
            rf_wa_d = rd_q;
            rf_wd_d = load_data;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access immediately
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      size_q      <= 3'd0;
      addr_lo_q   <= 2'd0;
      rd_q        <= 5'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rf_we_q     <= 1'b0;
      rf_wa_q     <= 5'd0;
      rf_wd_q     <= 32'd0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      addr_lo_q   <= addr_lo_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rf_we_q     <= rf_we_d;
      rf_wa_q     <= rf_wa_d;
      rf_wd_q     <= rf_wd_d;
      err_q       <= err_d;
    end
  end

  assign err_o       = err_q;
  assign rf_we_o     = rf_we_q;
  assign rf_wa_o     = rf_wa_q;
  assign rf_wd_o     = rf_wd_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
`default_nettype wire
